i_cache: RTL and testbench

I_CACHE -- requirements
Module: i_cache

---
 rtl/i_cache.sv | 136 +++++++++++++
 tb/tb_i_cache.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache with 256-bit lines and a blocking
// IDLE/MISS refill FSM; flush during refill drops the in-flight fill.
module i_cache #(
  parameter int unsigned LINES = 64,
  parameter int unsigned WORDS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           Instr_address_2IC,
  input  logic                  Instr_req_2IC,
  input  logic                  Flush_2IC,
  output logic [31:0]           Instr1_fIC,
  output logic [31:0]           Instr2_fIC,
  output logic                  STALL_fIC,
  output logic [31:0]           Instr_address_2IM,
  output logic                  iBlkRead,
  input  logic [32*WORDS-1:0]   block_read_fIM,
  input  logic                  block_read_fIM_valid,
  output logic [31:0]           Hit_count,
  output logic [31:0]           Miss_count
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 32 - 5 - IDX;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                r_state, w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [TAGW-1:0]       r_tag  [LINES];
  logic [32*WORDS-1:0]   r_data [LINES];
  logic                  r_drop;
  logic [31:0]           r_miss_addr;
  logic [31:0]           r_hit_cnt, r_miss_cnt;

  logic [2:0]            w_off;
  logic [IDX-1:0]        w_idx, w_fidx;
  logic [TAGW-1:0]       w_tag, w_ftag;
  logic                  w_hit;
  logic [32*WORDS-1:0]   w_line;
  logic [7:0]            w_base1, w_base2;
  logic                  w_unused_addr;

  assign w_off   = Instr_address_2IC[4:2];
  assign w_idx   = Instr_address_2IC[5+IDX-1:5];
  assign w_tag   = Instr_address_2IC[31:5+IDX];
  assign w_fidx  = r_miss_addr[5+IDX-1:5];
  assign w_ftag  = r_miss_addr[31:5+IDX];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line  = r_data[w_idx];
  assign w_base1 = {w_off, 5'd0};
  assign w_base2 = {w_off + 3'd1, 5'd0};
  assign w_unused_addr = ^Instr_address_2IC[1:0];

  assign Hit_count  = r_hit_cnt;
  assign Miss_count = r_miss_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    STALL_fIC         = 1'b0;
    iBlkRead          = 1'b0;
    Instr1_fIC        = '0;
    Instr2_fIC        = '0;
    Instr_address_2IM = '0;
    if (!RESET) begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            Instr1_fIC = w_line[w_base1 +: 32];
            if (w_off != 3'd7) Instr2_fIC = w_line[w_base2 +: 32];
          end
          if (Instr_req_2IC && !w_hit) begin
            STALL_fIC   = 1'b1;
            w_state_nxt = MISS;
          end
        end
        MISS: begin
          STALL_fIC         = 1'b1;
          iBlkRead          = 1'b1;
          Instr_address_2IM = r_miss_addr;
          if (block_read_fIM_valid) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid     <= '0;
      r_drop      <= 1'b0;
      r_miss_addr <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Flush_2IC) r_valid <= '0;
          if (Instr_req_2IC) begin
            if (w_hit) begin
              r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
              r_miss_cnt  <= r_miss_cnt + 32'd1;
              r_miss_addr <= {Instr_address_2IC[31:5], 5'd0};
            end
          end
        end
        MISS: begin
          if (Flush_2IC) begin
            r_valid <= '0;
            r_drop  <= 1'b1;
          end
          // A flush seen earlier in this miss, or in the fill cycle itself, keeps the line invalid
          if (block_read_fIM_valid) begin
            r_drop <= 1'b0;
            if (!Flush_2IC && !r_drop) r_valid[w_fidx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && r_state == MISS && block_read_fIM_valid) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= block_read_fIM;
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: cold miss, line hits, conflict, flush in IDLE/MISS,
// and reset during a refill.
module tb_i_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  Instr_address_2IC;
  logic         Instr_req_2IC;
  logic         Flush_2IC;
  logic [31:0]  Instr1_fIC, Instr2_fIC;
  logic         STALL_fIC;
  logic [31:0]  Instr_address_2IM;
  logic         iBlkRead;
  logic [255:0] block_read_fIM;
  logic         block_read_fIM_valid;
  logic [31:0]  Hit_count, Miss_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [31:0] A0   = 32'h0040_0000;
  localparam logic [31:0] A800 = 32'h0040_0800;
  localparam logic [31:0] B0   = 32'h2402_0001;
  localparam logic [31:0] B1   = 32'h1111_0000;

  i_cache #(.LINES(64), .WORDS(8)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .Instr_address_2IC    (Instr_address_2IC),
    .Instr_req_2IC        (Instr_req_2IC),
    .Flush_2IC            (Flush_2IC),
    .Instr1_fIC           (Instr1_fIC),
    .Instr2_fIC           (Instr2_fIC),
    .STALL_fIC            (STALL_fIC),
    .Instr_address_2IM    (Instr_address_2IM),
    .iBlkRead             (iBlkRead),
    .block_read_fIM       (block_read_fIM),
    .block_read_fIM_valid (block_read_fIM_valid),
    .Hit_count            (Hit_count),
    .Miss_count           (Miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] blk(input logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = base + 32'(i);
    return b;
  endfunction

  // Drive one cycle's inputs after the falling edge; outputs are sampled 1ns later.
  task automatic cyc(input logic rst, input logic req, input logic [31:0] addr,
                     input logic flush, input logic fill, input logic [31:0] base);
    @(negedge CLK);
    RESET                = rst;
    Instr_req_2IC        = req;
    Instr_address_2IC    = addr;
    Flush_2IC            = flush;
    block_read_fIM_valid = fill;
    block_read_fIM       = blk(base);
    #1;
  endtask

  initial begin
    RESET = 1'b1; Instr_req_2IC = 1'b0; Instr_address_2IC = '0; Flush_2IC = 1'b0;
    block_read_fIM_valid = 1'b0; block_read_fIM = '0;

    cyc(1, 1, A0, 0, 0, 0);
    cyc(1, 1, A0, 0, 0, 0);
    check("rst_stall", 32'(STALL_fIC), 0);
    check("rst_blkrd", 32'(iBlkRead), 0);
    check("rst_instr1", Instr1_fIC, 0);
    check("rst_imaddr", Instr_address_2IM, 0);
    check("rst_hits", Hit_count, 0);
    check("rst_miss", Miss_count, 0);

    cyc(0, 1, A0, 0, 0, 0);
    check("cold_stall", 32'(STALL_fIC), 1);
    check("cold_blkrd0", 32'(iBlkRead), 0);
    cyc(0, 1, A0 + 32'h20, 0, 0, 0);
    check("miss_blkrd", 32'(iBlkRead), 1);
    check("miss_imaddr", Instr_address_2IM, A0);
    check("miss_stall", 32'(STALL_fIC), 1);
    check("miss_instr1", Instr1_fIC, 0);
    check("miss_cnt1", Miss_count, 1);
    cyc(0, 1, A0, 0, 1, B0);
    check("fill_imaddr", Instr_address_2IM, A0);
    cyc(0, 1, A0, 0, 0, 0);
    check("cold_hit_stall", 32'(STALL_fIC), 0);
    check("cold_hit_i1", Instr1_fIC, B0);
    check("cold_hit_i2", Instr2_fIC, B0 + 1);

    for (int i = 1; i < 8; i++) begin
      cyc(0, 1, A0 + 32'(4*i), 0, 0, 0);
      if (i == 1) begin
        check("cold_hits", Hit_count, 1);
        check("cold_miss", Miss_count, 1);
      end
      check("line_stall", 32'(STALL_fIC), 0);
      check("line_i1", Instr1_fIC, B0 + 32'(i));
      check("line_i2", Instr2_fIC, (i == 7) ? 32'h0 : B0 + 32'(i + 1));
    end

    cyc(0, 0, A800, 0, 0, 0);
    check("noreq_stall", 32'(STALL_fIC), 0);
    check("line_hits", Hit_count, 8);
    cyc(0, 1, A800, 0, 0, 0);
    check("noreq_hits", Hit_count, 8);
    check("conf_stall", 32'(STALL_fIC), 1);
    cyc(0, 1, A800, 0, 1, B1);
    check("conf_imaddr", Instr_address_2IM, A800);
    cyc(0, 1, A800, 0, 0, 0);
    check("conf_hit_i1", Instr1_fIC, B1);
    check("conf_hit_stall", 32'(STALL_fIC), 0);
    cyc(0, 1, A0, 0, 0, 0);
    check("conf_remiss", 32'(STALL_fIC), 1);
    cyc(0, 1, A0, 0, 1, B0);
    cyc(0, 1, A0, 0, 0, 0);
    check("conf_rehit", Instr1_fIC, B0);
    check("conf_counts_m", Miss_count, 3);

    cyc(0, 1, A0, 1, 0, 0);
    check("flush_same_cyc", 32'(STALL_fIC), 0);
    check("flush_same_i1", Instr1_fIC, B0);
    cyc(0, 1, A0, 0, 0, 0);
    check("flush_miss", 32'(STALL_fIC), 1);
    check("flush_hits", Hit_count, 11);

    cyc(0, 1, A0, 1, 0, 0);
    check("mflush_blkrd", 32'(iBlkRead), 1);
    cyc(0, 1, A0, 0, 1, B0);
    cyc(0, 1, A0, 0, 0, 0);
    check("mflush_remiss", 32'(STALL_fIC), 1);
    check("mflush_miss", Miss_count, 4);
    cyc(0, 1, A0, 1, 1, B0);
    check("reassert_blkrd", 32'(iBlkRead), 1);
    cyc(0, 1, A0, 0, 0, 0);
    check("fflush_remiss", 32'(STALL_fIC), 1);
    check("fflush_miss", Miss_count, 5);

    cyc(0, 1, A0, 0, 0, 0);
    check("pre_rst_blkrd", 32'(iBlkRead), 1);
    check("pre_rst_miss", Miss_count, 6);
    cyc(1, 1, A0, 0, 0, 0);
    check("mrst_blkrd", 32'(iBlkRead), 0);
    check("mrst_stall", 32'(STALL_fIC), 0);
    cyc(0, 0, A0, 0, 1, B0);
    check("post_rst_blkrd", 32'(iBlkRead), 0);
    check("post_rst_hits", Hit_count, 0);
    check("post_rst_miss", Miss_count, 0);
    cyc(0, 1, A0, 0, 0, 0);
    check("post_rst_invalid", 32'(STALL_fIC), 1);
    check("post_rst_i1", Instr1_fIC, 0);

    cyc(0, 0, A0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
